// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel dispatcher.
//   COORD_W_DEF / X_MAX_DEF / Y_MAX_DEF : default coordinate width and frame
//                                         extents (1024 x 768 frame).
//   state_t : dispatcher FSM states.
//   coord_t : coordinate type at the default width.
//   rr_next : round-robin successor of an engine index.
package pixel_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int X_MAX_DEF   = 1023;
  localparam int Y_MAX_DEF   = 767;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  // Index of the engine that follows idx in a ring of n engines.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester.
//   ptr     : highest-priority requester index this cycle (must be < N).
//   gnt     : one-hot grant, all zero when no request is present.
//   gnt_idx : binary index of the granted requester (0 when none).
//   any     : at least one request is present.
// The pointer register is owned by the instantiating module; this block only
// searches from ptr upward, wrapping back to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  // Two passes replace a modulo search: first the requesters at or above
  // the pointer, then the ones below it. The first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
        any     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Frame-level pixel scheduler. Walks the frame in raster order and hands each
// coordinate to one of NUM_ENGINES iteration engines, then waits for every
// dispatched pixel to be retired before pulsing frame_done.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset.
//   start           : one-cycle pulse, starts a frame from IDLE only.
//   abort           : abandons the frame in DISPATCH/DRAIN (beats start and
//                     any transfer in the same cycle).
//   eng_ready[i]    : engine i can accept a pixel this cycle.
//   eng_done[i]     : one-cycle pulse, engine i retired one pixel.
//   eng_valid[i]    : dispatch strobe to engine i (one-hot or zero).
//   pix_x, pix_y    : coordinate offered to the granted engine.
//   busy            : high in DISPATCH and DRAIN.
//   frame_done      : one-cycle pulse when a frame completes.
//   err             : sticky outstanding-count over/underflow flag.
//   dbg_state       : current FSM state.
// Handshake: eng_valid is driven combinationally from eng_ready through the
// round-robin arbiter, so a pixel is transferred on every rising clock edge
// at which eng_valid is nonzero (valid and ready coincide by construction);
// at most one engine is granted per cycle.
module pixel_dispatcher
  import pixel_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_ENGINES-1:0] eng_ready,
  input  logic [NUM_ENGINES-1:0] eng_done,
  output logic [NUM_ENGINES-1:0] eng_valid,
  output logic [COORD_W-1:0]     pix_x,
  output logic [COORD_W-1:0]     pix_y,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output state_t                 dbg_state
);

  localparam int PTR_W   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int OUT_W   = $clog2(NUM_ENGINES + 1) + 1;
  localparam int OUT_MAX = NUM_ENGINES * 2;

  state_t               r_state, w_state_nxt;
  logic [COORD_W-1:0]   r_pix_x, r_pix_y, w_x_nxt, w_y_nxt;
  logic [PTR_W-1:0]     r_rr_ptr, w_ptr_nxt, w_gnt_idx;
  logic [OUT_W-1:0]     r_out, w_out_nxt;
  logic                 r_err, w_err_nxt;
  logic [NUM_ENGINES-1:0] w_gnt;
  logic                 w_any;
  logic                 w_active;
  logic                 w_xfer;
  logic                 w_clear;
  int                   w_sum;

  rr_arbiter #(
    .N     (NUM_ENGINES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (eng_ready),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_active = (r_state == DISPATCH) || (r_state == DRAIN);
  // abort suppresses the grant outright, so a transfer never happens in an
  // abort cycle.
  assign w_xfer   = (r_state == DISPATCH) && !abort && w_any;
  // Frame start and abort both zero the outstanding count, overriding any
  // retire pulses seen in that cycle.
  assign w_clear  = ((r_state == IDLE) && start) || (w_active && abort);

  // Outstanding counter: dispatch and retire in the same cycle net out; any
  // result outside [0, OUT_MAX] saturates and latches err.
  always_comb begin
    w_sum     = int'(r_out) + (w_xfer ? 1 : 0) - $countones(eng_done);
    w_out_nxt = r_out;
    w_err_nxt = r_err;
    if (w_clear) begin
      w_out_nxt = '0;
    end else if (w_sum < 0) begin
      w_out_nxt = '0;
      w_err_nxt = 1'b1;
    end else if (w_sum > OUT_MAX) begin
      w_out_nxt = OUT_W'(OUT_MAX);
      w_err_nxt = 1'b1;
    end else begin
      w_out_nxt = OUT_W'(w_sum);
    end
  end

  // Next-state and coordinate logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_pix_x;
    w_y_nxt     = r_pix_y;
    w_ptr_nxt   = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DISPATCH;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end
      end
      DISPATCH: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end else if (w_xfer) begin
          w_ptr_nxt = PTR_W'(rr_next(int'(w_gnt_idx), NUM_ENGINES));
          if (r_pix_x == COORD_W'(X_MAX)) begin
            w_x_nxt = '0;
            // The last pixel wraps the coordinates home instead of letting
            // Y run past the bottom row.
            if (r_pix_y == COORD_W'(Y_MAX)) begin
              w_y_nxt     = '0;
              w_state_nxt = DRAIN;
            end else begin
              w_y_nxt = r_pix_y + 1'b1;
            end
          end else begin
            w_x_nxt = r_pix_x + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end else if (w_out_nxt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_pix_x  <= '0;
      r_pix_y  <= '0;
      r_rr_ptr <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pix_x  <= w_x_nxt;
      r_pix_y  <= w_y_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_out    <= w_out_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Outputs decode directly from registered state so an asynchronous reset
  // clears them immediately.
  assign eng_valid  = w_xfer ? w_gnt : '0;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign busy       = w_active;
  assign frame_done = (r_state == DONE);
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pixel_dispatcher.sv
`timescale 1ns/1ps
module tb_pixel_dispatcher;
  import pixel_pkg::*;

  localparam int NE    = 2;
  localparam int CW    = 10;
  localparam int XM    = 3;
  localparam int YM    = 1;
  localparam int W     = XM + 1;
  localparam int TOTAL = W * (YM + 1);
  localparam int EW    = 8 + CW + CW;
  localparam int P_IDLE = 0, P_DISP = 1, P_DRAIN = 2, P_DONE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [NE-1:0] eng_ready, eng_done, eng_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic          busy, frame_done, err;
  state_t        dbg_state;

  always #5 clk = ~clk;

  pixel_dispatcher #(
    .NUM_ENGINES (NE),
    .COORD_W     (CW),
    .X_MAX       (XM),
    .Y_MAX       (YM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .eng_ready  (eng_ready),
    .eng_done   (eng_done),
    .eng_valid  (eng_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];   // expected transfers {engine, x, y}
  logic [2:0]    st_q[$];    // expected {busy, frame_done, err} per cycle
  int grant_log[$];
  int xfer_cnt = 0;
  int dut_fd   = 0;
  int exp_fd   = 0;
  logic chk_last = 1'b0;

  // reference model state (pixel index instead of x/y registers)
  int   m_phase = P_IDLE;
  int   m_n     = 0;
  int   m_ptr   = 0;
  int   m_out   = 0;
  logic m_err   = 1'b0;

  // engine emulation state
  int            due_q[NE][$];
  int            cyc = 0;
  int            ready_mode = 0;   // 0 all ready, 1 forced pattern, 2 random
  logic [NE-1:0] ready_force = '0;
  int            lat_min = 2;
  int            lat_max = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  // Evaluated on the falling edge with the inputs of the current cycle; it
  // queues what the DUT must show this cycle, then advances to the state
  // after the coming rising edge.
  always @(negedge clk) begin : ref_model
    int g, idx, sum;
    if (!rst) begin
      m_phase = P_IDLE; m_n = 0; m_ptr = 0; m_out = 0; m_err = 1'b0;
    end else begin
      g = -1;
      if (m_phase == P_DISP && !abort) begin
        for (int k = 0; k < NE; k++) begin
          idx = (m_ptr + k) % NE;
          if (g < 0 && ((eng_ready >> idx) & 1) != 0) g = idx;
        end
      end
      if (g >= 0) exp_q.push_back({8'(g), CW'(m_n % W), CW'(m_n / W)});
      st_q.push_back({(m_phase == P_DISP || m_phase == P_DRAIN), (m_phase == P_DONE), m_err});
      if (m_phase == P_DONE) exp_fd++;
      sum = m_out + ((g >= 0) ? 1 : 0) - $countones(eng_done);
      if ((m_phase == P_IDLE && start) || ((m_phase == P_DISP || m_phase == P_DRAIN) && abort))
        m_out = 0;
      else if (sum < 0) begin m_out = 0; m_err = 1'b1; end
      else if (sum > 2 * NE) begin m_out = 2 * NE; m_err = 1'b1; end
      else m_out = sum;
      case (m_phase)
        P_IDLE: if (start) begin m_phase = P_DISP; m_n = 0; end
        P_DISP: begin
          if (abort) begin m_phase = P_IDLE; m_n = 0; end
          else if (g >= 0) begin
            m_ptr = (g + 1) % NE;
            m_n++;
            if (m_n == TOTAL) begin m_n = 0; m_phase = P_DRAIN; end
          end
        end
        P_DRAIN: begin
          if (abort) m_phase = P_IDLE;
          else if (m_out == 0) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [2:0]    st;
    logic [EW-1:0] e;
    int            gi;
    #1;
    if (!rst) begin
      chk_last = 1'b0;
    end else begin
      if (chk_last) begin
        chk_last = 1'b0;
        check("after_last_state", 32'(dbg_state), 32'(DRAIN));
        check("after_last_x", 32'(pix_x), 32'd0);
        check("after_last_y", 32'(pix_y), 32'd0);
      end
      if (st_q.size() == 0) fail_msg("status_queue_empty");
      else begin
        st = st_q.pop_front();
        check("busy", 32'(busy), 32'(st[2]));
        check("frame_done", 32'(frame_done), 32'(st[1]));
        check("err", 32'(err), 32'(st[0]));
      end
      if (frame_done) dut_fd++;
      if (eng_valid != '0) begin
        gi = 0;
        for (int i = 0; i < NE; i++) if (eng_valid[i]) gi = i;
        check("onehot", 32'($onehot(eng_valid)), 32'd1);
        if (exp_q.size() == 0) fail_msg("unexpected_dispatch");
        else begin
          e = exp_q.pop_front();
          check("grant", 32'(gi), 32'(e[EW-1 -: 8]));
          check("pix_x", 32'(pix_x), 32'(e[2*CW-1 -: CW]));
          check("pix_y", 32'(pix_y), 32'(e[CW-1:0]));
        end
        grant_log.push_back(gi);
        xfer_cnt++;
        if (pix_x == CW'(XM) && pix_y == CW'(YM)) chk_last = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: engines learn of last cycle's dispatches, schedule their
  // retire pulses, then the next cycle's inputs are applied after the edge.
  task automatic step(input logic st, input logic ab, input logic [NE-1:0] md);
    logic [NE-1:0] v, dn, rdy;
    @(negedge clk); #2;
    v = eng_valid;
    @(posedge clk); #1;
    cyc++;
    for (int e = 0; e < NE; e++)
      if (v[e]) due_q[e].push_back(cyc + int'($urandom_range(lat_max, lat_min)) - 1);
    dn = '0;
    for (int e = 0; e < NE; e++) begin
      if (due_q[e].size() > 0 && due_q[e][0] <= cyc) begin
        void'(due_q[e].pop_front());
        dn[e] = 1'b1;
      end
    end
    if (ab) for (int e = 0; e < NE; e++) due_q[e].delete();
    for (int e = 0; e < NE; e++) begin
      if (ready_mode == 0)      rdy[e] = 1'b1;
      else if (ready_mode == 1) rdy[e] = ready_force[e];
      else                      rdy[e] = $urandom_range(1, 0) != 0;
      rdy[e] = rdy[e] && (due_q[e].size() < 2);
    end
    start     = st;
    abort     = ab;
    eng_done  = dn | md;
    eng_ready = rdy;
  endtask

  task automatic run_to_idle(input string name);
    int i = 0;
    do begin
      step(1'b0, 1'b0, '0);
      i++;
    end while (m_phase != P_IDLE && i < 400);
    if (m_phase != P_IDLE) fail_msg({name, "_timeout"});
    repeat (2) step(1'b0, 1'b0, '0);
    check({name, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_done_count"}, 32'(dut_fd), 32'(exp_fd));
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    for (int e = 0; e < NE; e++) due_q[e].delete();
    eng_ready = '0;
    eng_done  = '0;
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int i;
    rst = 1'b0; start = 1'b0; abort = 1'b0; eng_ready = '0; eng_done = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_eng_valid", 32'(eng_valid), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b0, '0);

    // full frame, both ready, retire 2 cycles after dispatch
    ready_mode = 0; lat_min = 2; lat_max = 2;
    grant_log.delete(); dut_fd = 0; exp_fd = 0;
    step(1'b1, 1'b0, '0);
    run_to_idle("full_frame");
    check("full_frame_grants", 32'(grant_log.size()), 32'(TOTAL));
    for (int k = 0; k < grant_log.size() && k < TOTAL; k++)
      check("full_frame_alternate", 32'(grant_log[k]), 32'(k % 2));
    check("full_frame_one_done", 32'(dut_fd), 32'd1);

    // fairness: only engine 1 ready for three cycles, then both
    ready_mode = 1; ready_force = 2'b10;
    grant_log.delete(); dut_fd = 0; exp_fd = 0;
    step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);
    ready_force = 2'b11;
    run_to_idle("fairness");
    if (grant_log.size() >= 5) begin
      check("fair_g0", 32'(grant_log[0]), 32'd1);
      check("fair_g1", 32'(grant_log[1]), 32'd1);
      check("fair_g2", 32'(grant_log[2]), 32'd1);
      check("fair_g3", 32'(grant_log[3]), 32'd0);
      check("fair_g4", 32'(grant_log[4]), 32'd1);
    end else fail_msg("fairness_too_few_grants");

    // randomized readiness and retire latency
    ready_mode = 2; lat_min = 1; lat_max = 4;
    for (int f = 0; f < 4; f++) begin
      dut_fd = 0; exp_fd = 0;
      repeat ($urandom_range(3, 0)) step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      run_to_idle("random_frame");
    end

    // abort after five transfers, then restart
    ready_mode = 0; lat_min = 2; lat_max = 2;
    xfer_cnt = 0; dut_fd = 0; exp_fd = 0;
    step(1'b1, 1'b0, '0);
    i = 0;
    while (xfer_cnt < 5 && i < 50) begin step(1'b0, 1'b0, '0); i++; end
    if (xfer_cnt < 5) fail_msg("abort_wait_timeout");
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    check("abort_state_idle", 32'(dbg_state), 32'(IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pix_x", 32'(pix_x), 32'd0);
    repeat (4) step(1'b0, 1'b0, '0);
    check("abort_no_frame_done", 32'(dut_fd), 32'd0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("restart_state", 32'(dbg_state), 32'(DISPATCH));
    check("restart_x", 32'(pix_x), 32'd0);
    check("restart_y", 32'(pix_y), 32'd0);
    run_to_idle("restart");

    // asynchronous reset mid-dispatch
    xfer_cnt = 0; dut_fd = 0; exp_fd = 0;
    step(1'b1, 1'b0, '0);
    i = 0;
    while (xfer_cnt < 3 && i < 50) begin step(1'b0, 1'b0, '0); i++; end
    async_reset();
    check("arst_eng_valid", 32'(eng_valid), 32'd0);
    check("arst_pix_x", 32'(pix_x), 32'd0);
    check("arst_pix_y", 32'(pix_y), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) step(1'b0, 1'b0, '0);
    check("arst_no_frame_done", 32'(dut_fd), 32'd0);

    // underflow: a retire pulse while idle sets a sticky err
    step(1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, '0);
    check("err_set", 32'(err), 32'd1);
    dut_fd = 0; exp_fd = 0;
    step(1'b1, 1'b0, '0);
    run_to_idle("err_frame");
    check("err_sticky", 32'(err), 32'd1);
    async_reset();
    check("err_cleared_by_reset", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) step(1'b0, 1'b0, '0);

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_dispatcher.md
Name: pixel_dispatcher

Overview:
- Frame-level scheduler that walks the screen in raster order and hands each pixel coordinate to one of NUM_ENGINES iteration engines.
- Uses a valid/ready handshake and round-robin arbitration among ready engines.
- Counts outstanding pixels and signals frame completion once every dispatched pixel has been retired.
- Sits between the frame control logic and the engine array, replacing the free-running pixel counter as the coordinate source.

Parameters:
- NUM_ENGINES, 4, number of engines sharing the coordinate stream (>=1).
- COORD_W, 10, width of the X and Y coordinates.
- X_MAX, 1023, last X column index (frame width - 1).
- Y_MAX, 767, last Y row index (frame height - 1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise.
- abort  in  1  synchronous; abandons the current frame.
- eng_ready  in  NUM_ENGINES  engine i can accept a pixel this cycle.
- eng_done  in  NUM_ENGINES  one-cycle pulse; engine i retired one pixel.
- eng_valid  out  NUM_ENGINES  one-hot (or zero) dispatch strobe.
- pix_x  out  COORD_W  coordinate offered to the granted engine.
- pix_y  out  COORD_W  coordinate offered to the granted engine.
- busy  out  1  high in DISPATCH and DRAIN.
- frame_done  out  1  one-cycle pulse when the frame completes.
- err  out  1  sticky; outstanding count over- or underflow.

Behaviour:
- Reset (rst=0, async): state=IDLE, pix_x=0, pix_y=0, outstanding=0, rr pointer=0, eng_valid=0, busy=0, frame_done=0, err=0. Reset mid-frame discards all progress; no frame_done is issued.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - start=1 -> DISPATCH with pix_x=0, pix_y=0, outstanding=0.
- DISPATCH:
  - Grant is combinational. eng_valid[g]=1 for the first i with eng_ready[i]=1, searching from rr_ptr upward and wrapping. All zero if no engine is ready.
  - A transfer occurs on any clock edge where eng_valid is nonzero. Zero-cycle handshake latency; at most one transfer per cycle.
  - On a transfer, rr_ptr := (g+1) mod NUM_ENGINES, and outstanding increments.
  - Coordinate advance on a transfer: if pix_x<X_MAX, pix_x+1. Otherwise pix_x := 0 and pix_y+1.
  - On a transfer of (X_MAX, Y_MAX): coordinates return to (0,0) and the state moves to DRAIN. Y never exceeds Y_MAX.
- DRAIN:
  - eng_valid=0.
  - Move to DONE when outstanding==0, including the same cycle's eng_done decrement.
- DONE:
  - frame_done=1 for exactly one cycle, then IDLE.
- Outstanding counter:
  - Width $clog2(NUM_ENGINES+1)+1.
  - Each cycle: += transfer, -= popcount(eng_done). A simultaneous dispatch and retire nets out.
  - Result <0, or >NUM_ENGINES*2: set err and saturate. err clears only on reset.
- abort in DISPATCH or DRAIN:
  - Next state IDLE, coordinates to (0,0), outstanding=0, eng_valid forced 0 that cycle, no frame_done.
  - abort has priority over start and over a transfer in the same cycle.
- start while busy: ignored.
- NUM_ENGINES=1: arbitration degenerates to eng_valid[0]=eng_ready[0].

Decomposition:
- Package pixel_pkg:
  - COORD_W, X_MAX, Y_MAX defaults.
  - state_t enum {IDLE, DISPATCH, DRAIN, DONE}.
  - coord_t typedef (logic [COORD_W-1:0]).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], gnt_idx, any.
  - Purely combinational. The pointer register lives in pixel_dispatcher.

Test Plan (bench parameters NUM_ENGINES=2, X_MAX=3, Y_MAX=1; 8 pixels):
- Full frame: start with both engines ready, each eng_done pulsed 2 cycles after its dispatch -> 8 transfers in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); grants alternate 0,1,0,1..; one frame_done pulse after the last done; busy low afterwards.
- Fairness: only engine 1 ready for 3 cycles, then both ready -> three grants to engine 1, next grant to engine 0, then engine 1.
- Row wrap: dispatch at (3,0) -> next offered coordinate is (0,1); after (3,1) the state is DRAIN and pix_x=pix_y=0.
- Drain with simultaneous events: last pixel dispatched in the same cycle as one eng_done while outstanding=2 -> outstanding stays 2; frame_done only after both remaining done pulses.
- Abort and reset: abort after 5 transfers -> IDLE next cycle, no frame_done; a new start restarts at (0,0). Drive rst=0 asynchronously mid-DISPATCH -> all outputs are 0 immediately, before the next clk edge.
- Error: eng_done pulsed in IDLE with outstanding=0 -> err=1 and stays 1 through subsequent frames until reset.
